pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Producer side of the program-counter interface: computes the 8-bit next-fetch address that the PC register captures on each rising `clock`.
- Takes the current PC output (`saida_pc`) and control-unit decisions: sequential, branch, jump, call, return, stall.
- Owns a small hardware return-address stack for call/return.
- Sits between the control unit and the PC register in the single-cycle datapath.

Parameters:
- ADDR_W, 8, address width; must match the PC register width.
- DEPTH, 4, number of return-stack entries (power of 2, ≥2).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- saida_pc  input  ADDR_W  current PC value (address of the instruction in execution).
- stall  input  1  hold current PC; highest priority.
- ret  input  1  return: pop the stack and go to the popped address.
- call  input  1  call: push saida_pc+1 and go to jump_target.
- jump  input  1  unconditional jump to jump_target.
- branch_taken  input  1  relative branch taken.
- branch_off  input  ADDR_W  signed two's-complement branch offset.
- jump_target  input  ADDR_W  absolute target for jump and call.
- address  output  ADDR_W  next PC value; connects to the PC register address input.
- stack_depth  output  $clog2(DEPTH)+1  current number of valid stack entries.
- overflow  output  1  sticky flag: a call was made with the stack full.
- underflow  output  1  sticky flag: a return was made with the stack empty.

Behaviour:
- `address` is combinational from the inputs and registered stack state; there is no added latency. The PC register loads it on the same edge.
- While `reset` = 1: `address` = 0, forcing the PC register to 0 on that edge.
- On a reset edge: stack pointer = 0, all entries = 0, `overflow` = 0, `underflow` = 0. `stack_depth` reads 0 from the cycle after reset.
- Select priority (highest first): reset > stall > ret > call > jump > branch_taken > sequential.
  - stall: `address` = saida_pc; no stack change.
  - ret, stack not empty: `address` = top entry; sp decrements at the edge.
  - ret, stack empty: `address` = saida_pc+1; sp stays 0; `underflow` is set at the edge.
  - call, stack not full: `address` = jump_target; saida_pc+1 is written to entry[sp]; sp increments.
  - call, stack full (sp = DEPTH): `address` = jump_target; push is discarded; sp unchanged; `overflow` is set.
  - jump: `address` = jump_target.
  - branch_taken: `address` = saida_pc + branch_off.
  - sequential: `address` = saida_pc + 1.
- Arithmetic is modulo 2^ADDR_W.
  - 0xFF + 1 = 0x00.
  - 0x02 + 0xFC (−4) = 0xFE.
  - The pushed return address wraps the same way.
- Simultaneous ret and call: ret wins. The call is ignored entirely (no push, no flag).
- Stall combined with any other request: all other requests are ignored and there is no stack or flag change.
- Sticky flags clear only on reset.
- Reset asserted mid-sequence (for example with call=1): reset wins. No push; state is cleared.
- No state machine beyond the stack pointer; the unit has two regimes, reset and normal.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W constant.
  - `next_sel_t` enum {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET, SEL_STALL}, used by the priority encoder and by the bench for coverage.
- Sub-module `ret_stack`:
  - Ports: clock, reset, push, pop, push_data, top, depth, full, empty.
  - Holds the LIFO and its pointer.
  - The parent computes selection, the adders and the sticky flags.

Test Plan:
1. Reset, then sequential stepping: assert reset with saida_pc=0x37 → address=0x00. Release; saida_pc=0x00, no requests → address=0x01. saida_pc=0xFF → address=0x00.
2. Branch: saida_pc=0x10, branch_taken=1, branch_off=0xFC → address=0x0C. With branch_off=0x05 → address=0x15. With stall=1 also asserted → address=0x10.
3. Nested calls and returns:
   - call at saida_pc=0x20 to 0x80 → address=0x80, depth=1.
   - call at 0x85 to 0xA0 → address=0xA0, depth=2.
   - ret → address=0x86, depth=1.
   - ret → address=0x21, depth=0.
4. Overflow: five calls at 0x01..0x05 to 0x40 → depth saturates at 4, overflow=1 after the 5th. Four rets return 0x05, 0x04, 0x03, 0x02. Then ret → address=saida_pc+1 and underflow=1.
5. Conflicts:
   - ret+call together with stack holding 0x33 → address=0x33, depth decrements, overflow unchanged.
   - jump+branch_taken with jump_target=0x90 → address=0x90.
6. Reset during call: depth=2, then reset=1 with call=1 → address=0x00. Next cycle: depth=0, overflow=0, underflow=0. A following ret → underflow=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: address width and the next-PC source selector.
package cpu_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET,
        SEL_STALL
    } next_sel_t;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO. The caller never asserts push and pop together.
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_sp;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    // With sp == DEPTH the low bits wrap to 0, so sp-1 still lands on the last slot.
    assign w_wr_idx  = r_sp[AW-1:0];
    assign w_top_idx = r_sp[AW-1:0] - AW'(1);

    assign top   = r_mem[w_top_idx];
    assign depth = r_sp;
    assign full  = (r_sp == (AW+1)'(DEPTH));
    assign empty = (r_sp == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
            r_sp            <= r_sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-fetch address generator: priority select over stall/ret/call/jump/branch/seq
// with a return-address stack and sticky overflow/underflow flags.
module pc_next_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       saida_pc,
    input  logic                    stall,
    input  logic                    ret,
    input  logic                    call,
    input  logic                    jump,
    input  logic                    branch_taken,
    input  logic [ADDR_W-1:0]       branch_off,
    input  logic [ADDR_W-1:0]       jump_target,
    output logic [ADDR_W-1:0]       address,
    output logic [$clog2(DEPTH):0]  stack_depth,
    output logic                    overflow,
    output logic                    underflow
);
    import cpu_pkg::*;

    next_sel_t         w_sel;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              r_overflow;
    logic              r_underflow;

    assign w_inc = saida_pc + ADDR_W'(1);
    assign w_br  = saida_pc + branch_off;

    always_comb begin
        w_sel = SEL_SEQ;
        if (stall)             w_sel = SEL_STALL;
        else if (ret)          w_sel = SEL_RET;
        else if (call)         w_sel = SEL_CALL;
        else if (jump)         w_sel = SEL_JUMP;
        else if (branch_taken) w_sel = SEL_BRANCH;
    end

    always_comb begin
        address = w_inc;
        if (reset) begin
            address = '0;
        end else begin
            case (w_sel)
                SEL_STALL:  address = saida_pc;
                SEL_RET:    address = w_empty ? w_inc : w_top;
                SEL_CALL:   address = jump_target;
                SEL_JUMP:   address = jump_target;
                SEL_BRANCH: address = w_br;
                default:    address = w_inc;
            endcase
        end
    end

    assign w_push = !reset && (w_sel == SEL_CALL) && !w_full;
    assign w_pop  = !reset && (w_sel == SEL_RET) && !w_empty;

    ret_stack #(.W(ADDR_W), .DEPTH(DEPTH)) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_inc),
        .top       (w_top),
        .depth     (stack_depth),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_sel == SEL_CALL && w_full)  r_overflow  <= 1'b1;
            if (w_sel == SEL_RET  && w_empty) r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: queue-based reference model checked every cycle,
// directed literal checks plus randomized traffic.
module tb_pc_next_unit;
    import cpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] saida_pc;
    logic       stall, ret, call, jump, branch_taken;
    logic [7:0] branch_off, jump_target;
    logic [7:0] address;
    logic [2:0] stack_depth;
    logic       overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    pc_next_unit dut (
        .clock        (clock),
        .reset        (reset),
        .saida_pc     (saida_pc),
        .stall        (stall),
        .ret          (ret),
        .call         (call),
        .jump         (jump),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_target  (jump_target),
        .address      (address),
        .stack_depth  (stack_depth),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    // Reference model: return addresses in a queue, flags as bits.
    int m_stk[$];
    bit m_ovf, m_unf, m_valid;
    int sel_hits[6];

    function automatic next_sel_t m_sel();
        if (stall)             return SEL_STALL;
        if (ret)               return SEL_RET;
        if (call)              return SEL_CALL;
        if (jump)              return SEL_JUMP;
        if (branch_taken)      return SEL_BRANCH;
        return SEL_SEQ;
    endfunction

    function automatic int m_addr();
        int pc = int'(saida_pc);
        if (reset) return 0;
        case (m_sel())
            SEL_STALL:  return pc;
            SEL_RET:    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : (pc + 1) % 256;
            SEL_CALL:   return int'(jump_target);
            SEL_JUMP:   return int'(jump_target);
            SEL_BRANCH: return (pc + int'(branch_off)) % 256;
            default:    return (pc + 1) % 256;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_stk.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            sel_hits[int'(m_sel())]++;
            if (m_sel() == SEL_RET) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1'b1;
            end else if (m_sel() == SEL_CALL) begin
                if (m_stk.size() < 4) m_stk.push_back((int'(saida_pc) + 1) % 256);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid || reset) chk("model_addr", int'(address), m_addr());
        if (m_valid) begin
            chk("model_depth", int'(stack_depth), m_stk.size());
            chk("model_ovf", int'(overflow), int'(m_ovf));
            chk("model_unf", int'(underflow), int'(m_unf));
        end
    end

    task automatic set(input logic [7:0] pc, input logic st = 0, input logic rt = 0,
                       input logic cl = 0, input logic jp = 0, input logic br = 0,
                       input logic [7:0] off = 0, input logic [7:0] tgt = 0);
        saida_pc = pc; stall = st; ret = rt; call = cl; jump = jp;
        branch_taken = br; branch_off = off; jump_target = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set(8'h37);
        chk("rst_addr", int'(address), 8'h00);
        tick();
        chk("rst_depth", int'(stack_depth), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b0;

        // 1. sequential
        set(8'h00);                chk("seq_00", int'(address), 8'h01); tick();
        set(8'hFF);                chk("seq_wrap", int'(address), 8'h00); tick();
        // 2. branch
        set(8'h10, 0,0,0,0,1, 8'hFC); chk("br_neg", int'(address), 8'h0C); tick();
        set(8'h10, 0,0,0,0,1, 8'h05); chk("br_pos", int'(address), 8'h15); tick();
        set(8'h10, 1,0,0,0,1, 8'h05); chk("br_stall", int'(address), 8'h10); tick();
        // 3. nested calls
        set(8'h20, 0,0,1,0,0, 0, 8'h80); chk("call1", int'(address), 8'h80); tick();
        chk("call1_depth", int'(stack_depth), 1);
        set(8'h85, 0,0,1,0,0, 0, 8'hA0); chk("call2", int'(address), 8'hA0); tick();
        chk("call2_depth", int'(stack_depth), 2);
        set(8'hA0, 0,1);           chk("ret1", int'(address), 8'h86); tick();
        chk("ret1_depth", int'(stack_depth), 1);
        set(8'h86, 0,1);           chk("ret2", int'(address), 8'h21); tick();
        chk("ret2_depth", int'(stack_depth), 0);
        // 4. overflow and underflow
        for (int i = 1; i <= 5; i++) begin
            set(8'(i), 0,0,1,0,0, 0, 8'h40); tick();
        end
        chk("ovf_depth", int'(stack_depth), 4);
        chk("ovf_flag", int'(overflow), 1);
        for (int i = 5; i >= 2; i--) begin
            set(8'h40, 0,1);       chk("ovf_ret", int'(address), i); tick();
        end
        set(8'h50, 0,1);           chk("unf_addr", int'(address), 8'h51); tick();
        chk("unf_flag", int'(underflow), 1);
        // 5. conflicts
        set(8'h32, 0,0,1,0,0, 0, 8'h60); tick();
        set(8'h60, 0,1,1,0,0, 0, 8'h77); chk("retcall", int'(address), 8'h33); tick();
        chk("retcall_depth", int'(stack_depth), 0);
        chk("retcall_ovf", int'(overflow), 1);
        set(8'h33, 0,0,0,1,1, 8'h04, 8'h90); chk("jmp_br", int'(address), 8'h90); tick();
        // 6. reset during call
        set(8'h10, 0,0,1,0,0, 0, 8'h20); tick();
        set(8'h20, 0,0,1,0,0, 0, 8'h30); tick();
        chk("pre_rst_depth", int'(stack_depth), 2);
        reset = 1'b1;
        set(8'h30, 0,0,1,0,0, 0, 8'h44); chk("rst_call", int'(address), 8'h00); tick();
        reset = 1'b0;
        chk("post_rst_depth", int'(stack_depth), 0);
        chk("post_rst_ovf", int'(overflow), 0);
        chk("post_rst_unf", int'(underflow), 0);
        set(8'h00, 0,1);           chk("post_rst_ret", int'(address), 8'h01); tick();
        chk("post_rst_unf2", int'(underflow), 1);

        // randomized traffic, occasional reset
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            set(8'($urandom), $urandom_range(0,7) == 0, $urandom_range(0,3) == 0,
                $urandom_range(0,2) == 0, $urandom_range(0,5) == 0,
                $urandom_range(0,2) == 0, 8'($urandom), 8'($urandom));
            tick();
        end
        reset = 1'b0;

        $display("[TB] select hits seq=%0d br=%0d jmp=%0d call=%0d ret=%0d stall=%0d",
                 sel_hits[0], sel_hits[1], sel_hits[2], sel_hits[3], sel_hits[4], sel_hits[5]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
